// File: rtl/spi_reg_streamer.sv
// spi_reg_streamer: walks a register-index range, reads each word from the
// register file read port and streams {3'b000, index, data} MSB first as an
// SPI mode-0 master frame. Chip select stays low across all words of a frame.
module spi_reg_streamer #(
  parameter int W_DATA  = 32,
  parameter int CLK_DIV = 4    // SPI half-period in clk cycles, must be >= 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        first_reg,
  input  logic [4:0]        last_reg,
  output logic [4:0]        ra,
  input  logic [W_DATA-1:0] rd,
  output logic              busy,
  output logic              dv_spi,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi
);

  localparam int SW = W_DATA + 8;
  localparam int BW = $clog2(SW + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    TAIL
  } state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [4:0]      last_q;
  logic [SW-1:0]   shreg;
  logic [DW-1:0]   div;
  logic [BW-1:0]   bitcnt;
  logic [SW-1:0]   load_word;

  // Header byte followed by the word currently presented on the read port
  always_comb begin
    load_word = {3'b000, idx, rd};
  end

  // Frame sequencer: address walk, SPI bit timing and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      last_q   <= '0;
      shreg    <= '0;
      div      <= '0;
      bitcnt   <= '0;
      ra       <= '0;
      busy     <= 1'b0;
      dv_spi   <= 1'b0;
      done     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      dv_spi <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx    <= first_reg;
            last_q <= last_reg;
            ra     <= first_reg;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          shreg    <= load_word;
          spi_cs_n <= 1'b0;
          spi_mosi <= load_word[SW-1];
          div      <= '0;
          bitcnt   <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              // Falling edge: present the next bit for the slave's next rise
              spi_sclk <= 1'b0;
              shreg    <= {shreg[SW-2:0], 1'b0};
              spi_mosi <= shreg[SW-2];
              bitcnt   <= bitcnt + 1'b1;
              if (bitcnt == BIT_LAST) begin
                dv_spi <= 1'b1;
                if (idx != last_q) begin
                  idx   <= idx + 5'd1;
                  ra    <= idx + 5'd1;
                  state <= LOAD;
                end else begin
                  state <= TAIL;
                end
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        TAIL: begin
          // div was cleared on the last falling edge; hold CS low one half-period
          if (div == DIV_LAST) begin
            spi_cs_n <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
